if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/if_id_queue.sv | 100 ++++++++++
 tb/tb_if_id_queue.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and types.
// Default datapath widths and the canonical NOP encoding.
package riscv_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned ILEN_DEF = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN_DEF-1:0] ins;
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] pc_plus_4;
  } if_id_t;

  function automatic logic is_pow2(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue between fetch and decode.
// Registered-state handshakes; flush drops every queued entry.
module if_id_queue
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned ILEN  = ILEN_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid_in,
  output logic                       if_ready_out,
  input  logic [ILEN-1:0]            if_ins_in,
  input  logic [XLEN-1:0]            if_pc_in,
  input  logic [XLEN-1:0]            if_pc_plus_4_in,
  output logic                       id_valid_out,
  input  logic                       id_ready_in,
  output logic [ILEN-1:0]            id_ins_out,
  output logic [XLEN-1:0]            id_pc_out,
  output logic [XLEN-1:0]            id_pc_plus_4_out,
  input  logic                       flush_in,
  output logic [$clog2(DEPTH):0]     count_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = ILEN + 2 * XLEN;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  assign if_ready_out = (count_q < FULL);
  assign id_valid_out = (count_q != '0);
  assign count_out    = count_q;

  // Handshakes are qualified by flush so a redirect drops the beat.
  assign push = if_valid_in & if_ready_out & ~flush_in;
  assign pop  = id_valid_out & id_ready_in & ~flush_in;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the control state above does.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_q[wr_ptr_q] <= {if_ins_in, if_pc_in, if_pc_plus_4_in};
    end
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    id_ins_out       = ILEN'(NOP_INS);
    id_pc_out        = '0;
    id_pc_plus_4_out = '0;
    if (id_valid_out) begin
      id_ins_out       = head[EW-1 -: ILEN];
      id_pc_out        = head[2*XLEN-1 -: XLEN];
      id_pc_plus_4_out = head[XLEN-1:0];
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue.
// Queue-based reference model with directed and random traffic.
module tb_if_id_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vin = 1'b0;
  logic        if_ready;
  logic [31:0] ins = '0;
  logic [31:0] pc = '0;
  logic [31:0] pc4 = '0;
  logic        id_valid;
  logic        rdy = 1'b0;
  logic [31:0] id_ins;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        flush = 1'b0;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  logic [95:0] mq [$];

  if_id_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_valid_in      (vin),
    .if_ready_out     (if_ready),
    .if_ins_in        (ins),
    .if_pc_in         (pc),
    .if_pc_plus_4_in  (pc4),
    .id_valid_out     (id_valid),
    .id_ready_in      (rdy),
    .id_ins_out       (id_ins),
    .id_pc_out        (id_pc),
    .id_pc_plus_4_out (id_pc4),
    .flush_in         (flush),
    .count_out        (count)
  );

  always #5 clk = ~clk;

  // One clock edge; the model applies the queue rules to pre-edge inputs.
  task automatic cycle();
    bit do_push, do_pop;
    logic [95:0] e;
    int sz;
    sz = mq.size();
    e = {ins, pc, pc4};
    do_push = vin && (sz < DEPTH);
    do_pop  = rdy && (sz > 0);
    @(posedge clk);
    if (!rst || flush) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    #1;
  endtask

  task automatic set_entry(input int i);
    ins = 32'h0010_0093 + (i << 20);
    pc  = 32'h100 + 4 * i;
    pc4 = pc + 4;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    n_cmp++;
    if ({id_valid, if_ready, count} !== {1'b0, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL reset_ctrl: got v=%b r=%b c=%0d want v=0 r=1 c=0",
               id_valid, if_ready, count);
    end
    n_cmp++;
    if ({id_ins, id_pc, id_pc4} !== {32'h13, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_data: got %h %h %h want 00000013 0 0",
               id_ins, id_pc, id_pc4);
    end
  endtask

  task automatic test_single_push();
    vin = 1'b1;
    ins = 32'h0050_0093;
    pc  = 32'h0;
    pc4 = 32'h4;
    cycle();
    vin = 1'b0;
    n_cmp++;
    if ({id_valid, count, id_pc4, id_ins} !==
        {1'b1, 3'd1, 32'h4, 32'h0050_0093}) begin
      n_err++;
      $display("FAIL single_push: got v=%b c=%0d pc4=%h ins=%h want 1 1 4 00500093",
               id_valid, count, id_pc4, id_ins);
    end
    rdy = 1'b1;
    cycle();
    rdy = 1'b0;
    n_cmp++;
    if ({id_valid, count, id_ins} !== {1'b0, 3'd0, 32'h13}) begin
      n_err++;
      $display("FAIL single_drain: got v=%b c=%0d ins=%h want 0 0 00000013",
               id_valid, count, id_ins);
    end
  endtask

  task automatic test_fill();
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_entry(i);
      vin = 1'b1;
      n_cmp++;
      if (if_ready !== (i < 4)) begin
        n_err++;
        $display("FAIL fill_ready_%0d: got %b want %b", i, if_ready, i < 4);
      end
      cycle();
    end
    vin = 1'b0;
    n_cmp++;
    if ({if_ready, count, id_pc} !== {1'b0, 3'd4, 32'h100}) begin
      n_err++;
      $display("FAIL fill_full: got r=%b c=%0d pc=%h want 0 4 00000100",
               if_ready, count, id_pc);
    end
  endtask

  task automatic test_full_stream();
    for (int i = 5; i < 13; i++) begin
      set_entry(i);
      vin = 1'b1;
      rdy = 1'b1;
      n_cmp++;
      if ({count, id_ins, id_pc, id_pc4} !== {3'(mq.size()), mq[0]} ||
          count < 3) begin
        n_err++;
        $display("FAIL stream_%0d: got c=%0d %h/%h/%h want c=%0d %h",
                 i, count, id_ins, id_pc, id_pc4, mq.size(), mq[0]);
      end
      cycle();
    end
    vin = 1'b0;
    while (mq.size() > 0) begin
      n_cmp++;
      if ({id_valid, id_ins, id_pc, id_pc4} !== {1'b1, mq[0]}) begin
        n_err++;
        $display("FAIL stream_drain: got %h/%h/%h want %h",
                 id_ins, id_pc, id_pc4, mq[0]);
      end
      cycle();
    end
    rdy = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 20; i < 23; i++) begin
      set_entry(i);
      vin = 1'b1;
      cycle();
    end
    n_cmp++;
    if (count !== 3'd3) begin
      n_err++;
      $display("FAIL flush_pre: got c=%0d want 3", count);
    end
    set_entry(23);
    flush = 1'b1;
    rdy = 1'b1;
    cycle();
    flush = 1'b0;
    vin = 1'b0;
    rdy = 1'b0;
    n_cmp++;
    if ({count, id_valid, if_ready, id_ins} !==
        {3'd0, 1'b0, 1'b1, 32'h13}) begin
      n_err++;
      $display("FAIL flush_post: got c=%0d v=%b r=%b ins=%h want 0 0 1 00000013",
               count, id_valid, if_ready, id_ins);
    end
    cycle();
    n_cmp++;
    if ({count, id_valid} !== {3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL flush_lost: got c=%0d v=%b want 0 0", count, id_valid);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 30; i < 32; i++) begin
      set_entry(i);
      vin = 1'b1;
      cycle();
    end
    vin = 1'b1;
    rdy = 1'b1;
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    vin = 1'b0;
    rdy = 1'b0;
    n_cmp++;
    if ({count, if_ready, id_valid, id_pc} !==
        {3'd0, 1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_mid: got c=%0d r=%b v=%b pc=%h want 0 1 0 0",
               count, if_ready, id_valid, id_pc);
    end
  endtask

  task automatic test_random();
    logic [98:0] exp;
    for (int i = 0; i < 1000; i++) begin
      vin   = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 49) == 0);
      rst   = ($urandom_range(0, 199) != 0);
      ins   = $urandom;
      pc    = $urandom & 32'hffff_fffc;
      pc4   = pc + 4;
      cycle();
      if (mq.size() > 0) exp = {1'b1, mq.size() < DEPTH, 1'b1, mq[0]};
      else exp = {1'b0, 1'b1, 1'b0, 32'h13, 64'h0};
      n_cmp++;
      if ({id_valid, if_ready, count != 0, id_ins, id_pc, id_pc4} !== exp ||
          count !== 3'(mq.size())) begin
        n_err++;
        $display("FAIL random_%0d: got v=%b r=%b c=%0d %h/%h/%h want c=%0d %h",
                 i, id_valid, if_ready, count, id_ins, id_pc, id_pc4,
                 mq.size(), exp);
      end
    end
    rst = 1'b1;
    flush = 1'b0;
    vin = 1'b0;
    rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill();
    test_full_stream();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
